// File: rtl/omux_pkg.sv
// Shared types and constants for the output multiplexer: record size, source-index
// width helper, FSM state encoding and the output FIFO entry.
package omux_pkg;

  localparam int OMUX_RECORD_BYTES = 16;
  // Wide enough for up to 256 sources; the top keeps only the low bits it needs.
  localparam int OMUX_SRC_FIELD_W  = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } omux_state_e;

  typedef struct packed {
    logic [7:0]                  data;
    logic                        last;
    logic [OMUX_SRC_FIELD_W-1:0] src;
  } omux_entry_t;

  function automatic int src_idx_w(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/omux_if.sv
// Source-side select bus and host-side byte stream of the output multiplexer.
// Stream handshake: a byte moves on every clock edge where out_valid && out_ready;
// while out_valid && !out_ready the data/last/src fields hold stable.
interface omux_if #(
  parameter int NSRC  = 2,
  parameter int SRC_W = omux_pkg::src_idx_w(NSRC)
) ();

  logic [NSRC-1:0]   omux_req;
  logic [NSRC-1:0]   omux_sel;
  logic [8*NSRC-1:0] omux_data;

  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_last;
  logic [SRC_W-1:0]  out_src;
  logic              out_ready;

  modport master (
    input  omux_req, omux_data, out_ready,
    output omux_sel, out_data, out_valid, out_last, out_src
  );

  modport slave (
    output omux_req, omux_data, out_ready,
    input  omux_sel, out_data, out_valid, out_last, out_src
  );

endinterface

// File: rtl/omux_skid_fifo.sv
// Two-entry FIFO with registered head; the head register drives the output fields
// directly so they stay stable while the consumer stalls.
module omux_skid_fifo
  import omux_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  omux_entry_t push_data_i,
  input  logic        pop_i,
  output omux_entry_t head_o,
  output logic [1:0]  count_o
);

  omux_entry_t head_q, head_d;
  omux_entry_t tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        push_ok, pop_ok;

  assign push_ok = push_i && (count_q != 2'd2);
  assign pop_ok  = pop_i && (count_q != 2'd0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count unchanged; the older tail entry moves up ahead of the new byte.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/omux_arbiter.sv
// Round-robin output arbiter: grants one record buffer per record and moves its
// bytes into a byte-wide ready/valid stream through a two-entry FIFO.
module omux_arbiter
  import omux_pkg::*;
#(
  parameter int NSRC         = 2,
  parameter int RECORD_BYTES = OMUX_RECORD_BYTES
) (
  input  logic        clk_i,
  input  logic        reset_i,
  omux_if.master      bus,
  output logic [31:0] records_sent_o,
  output omux_state_e state_o
);

  localparam int SRC_W = src_idx_w(NSRC);
  localparam int CNT_W = $clog2(RECORD_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RECORD_BYTES - 1);
  localparam logic [SRC_W-1:0] RR_INIT  = SRC_W'(NSRC - 1);

  omux_state_e      state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_last_q, rr_last_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      records_q, records_d;

  logic [SRC_W-1:0] pick;
  logic [SRC_W-1:0] idx;
  logic             found;
  logic [NSRC-1:0]  sel;
  logic             push;
  omux_entry_t      push_entry;
  omux_entry_t      head;
  logic [1:0]       fifo_count;
  logic             pop;
  logic             unused_src_bits;

  // First requester strictly after rr_last, wrapping modulo NSRC.
  always_comb begin
    pick  = rr_last_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NSRC; i++) begin
      idx = SRC_W'((int'(rr_last_q) + i) % NSRC);
      if (!found && bus.omux_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    byte_cnt_d = byte_cnt_q;
    sel        = '0;
    push       = 1'b0;
    push_entry.data = bus.omux_data[int'(grant_q)*8 +: 8];
    push_entry.last = (byte_cnt_q == LAST_CNT);
    push_entry.src  = OMUX_SRC_FIELD_W'(grant_q);
    case (state_q)
      ST_IDLE: begin
        if (|bus.omux_req) begin
          grant_d    = pick;
          byte_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        // Uses only the registered FIFO count, never out_ready.
        if (bus.omux_req[grant_q] && (fifo_count != 2'd2)) begin
          sel[grant_q] = 1'b1;
          push         = 1'b1;
          byte_cnt_d   = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == LAST_CNT) begin
            rr_last_d = grant_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  omux_skid_fifo u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign pop       = (fifo_count != 2'd0) && bus.out_ready;
  assign records_d = (pop && head.last) ? records_q + 32'd1 : records_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_last_q  <= RR_INIT;
      byte_cnt_q <= '0;
      records_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      byte_cnt_q <= byte_cnt_d;
      records_q  <= records_d;
    end
  end

  assign bus.omux_sel   = sel;
  assign bus.out_valid  = (fifo_count != 2'd0);
  assign bus.out_data   = head.data;
  assign bus.out_last   = head.last;
  assign bus.out_src    = head.src[SRC_W-1:0];
  assign unused_src_bits = ^head.src;
  assign records_sent_o = records_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_omux_arbiter.sv
// Directed bench for omux_arbiter: modelled byte sources, a negedge monitor and
// one task per scenario comparing received bytes against an expected queue.
module tb_omux_arbiter;
  import omux_pkg::*;

  localparam int NSRC = 2;
  localparam int RB   = 16;
  localparam int W    = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready = 1'b0;
  always #5 clk = ~clk;

  omux_if #(.NSRC(NSRC)) bus ();
  logic [31:0] records_sent;
  omux_state_e dut_state;

  omux_arbiter #(.NSRC(NSRC), .RECORD_BYTES(RB)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .bus            (bus),
    .records_sent_o (records_sent),
    .state_o        (dut_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Source model: each source offers `budget` bytes starting at base, counted by taken.
  int          taken [NSRC];
  int          origin[NSRC];
  int          budget[NSRC];
  logic        hold  [NSRC];
  logic [7:0]  base  [NSRC];
  logic [NSRC-1:0] take;

  logic [W-1:0]    rx_q[$];
  logic [W-1:0]    exp_q[$];
  logic [NSRC-1:0] sel_trace[$];

  always_comb begin
    bus.omux_req  = '0;
    bus.omux_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      bus.omux_req[k]          = ((taken[k] - origin[k]) < budget[k]) && !hold[k];
      bus.omux_data[8*k +: 8]  = base[k] + 8'(taken[k] - origin[k]);
    end
  end
  assign bus.out_ready = ready;

  always @(negedge clk) begin
    take = reset ? '0 : bus.omux_sel;
    sel_trace.push_back(bus.omux_sel);
    if (!reset && bus.out_valid && ready)
      rx_q.push_back({bus.out_src, bus.out_last, bus.out_data});
  end

  always @(posedge clk) begin
    for (int k = 0; k < NSRC; k++)
      if (take[k]) taken[k] <= taken[k] + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic start_src(input int k, input int b, input logic [7:0] bv);
    origin[k] = taken[k];
    budget[k] = b;
    base[k]   = bv;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      hold[k]   = 1'b0;
      budget[k] = 0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < NSRC; k++) origin[k] = taken[k];
  endtask

  task automatic wait_rx(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_record(input logic src, input logic [7:0] first);
    for (int i = 0; i < RB; i++)
      exp_q.push_back({src, (i == RB - 1), 8'(first + 8'(i))});
  endtask

  task automatic compare_rx(input string tag);
    logic [W-1:0] got;
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s rx_count: got %0d want %0d", tag, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : '1;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s byte[%0d] {src,last,data}: got %h want %h", tag, i, got, exp_q[i]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    n_cmp++; if (bus.omux_sel !== 2'b00) begin n_bad++; $display("FAIL reset sel: got %b want 00", bus.omux_sel); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset last: got %b want 0", bus.out_last); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL reset data: got %h want 00", bus.out_data); end
    n_cmp++; if (bus.out_src !== 1'b0) begin n_bad++; $display("FAIL reset src: got %h want 0", bus.out_src); end
    n_cmp++; if (records_sent !== 32'd0) begin n_bad++; $display("FAIL reset records: got %0d want 0", records_sent); end
    n_cmp++; if (dut_state !== ST_IDLE) begin n_bad++; $display("FAIL reset state: got %0d want IDLE", dut_state); end
  endtask

  task automatic test_single_record();
    bit ok;
    int n_sel0, n_sel1;
    reset_dut();
    rx_q.delete(); exp_q.delete(); sel_trace.delete();
    ready = 1'b1;
    start_src(0, RB, 8'h00);
    push_record(1'b0, 8'h00);
    wait_rx(RB, 80, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single timeout: got %0d bytes want %0d", rx_q.size(), RB); end
    idle_cycles(4);
    compare_rx("single");
    n_sel0 = 0; n_sel1 = 0;
    foreach (sel_trace[i]) begin
      if (sel_trace[i][0]) n_sel0++;
      if (sel_trace[i][1]) n_sel1++;
    end
    n_cmp++; if (n_sel0 != RB) begin n_bad++; $display("FAIL single sel0_cycles: got %0d want %0d", n_sel0, RB); end
    n_cmp++; if (n_sel1 != 0) begin n_bad++; $display("FAIL single sel1_cycles: got %0d want 0", n_sel1); end
    n_cmp++; if (sel_trace[0] !== 2'b00) begin n_bad++; $display("FAIL single sel_latency0: got %b want 00", sel_trace[0]); end
    n_cmp++; if (sel_trace[1] !== 2'b01) begin n_bad++; $display("FAIL single sel_latency1: got %b want 01", sel_trace[1]); end
    @(negedge clk);
    n_cmp++; if (records_sent !== 32'd1) begin n_bad++; $display("FAIL single records: got %0d want 1", records_sent); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int first, bad_pat;
    logic [NSRC-1:0] want, got;
    reset_dut();
    rx_q.delete(); exp_q.delete(); sel_trace.delete();
    ready = 1'b1;
    start_src(0, 2*RB, 8'h00);
    start_src(1, 2*RB, 8'h80);
    push_record(1'b0, 8'h00);
    push_record(1'b1, 8'h80);
    push_record(1'b0, 8'h10);
    push_record(1'b1, 8'h90);
    wait_rx(4*RB, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr timeout: got %0d bytes want %0d", rx_q.size(), 4*RB); end
    idle_cycles(3);
    compare_rx("rr");
    first = -1;
    foreach (sel_trace[i]) if (first < 0 && sel_trace[i] != 0) first = i;
    bad_pat = 0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j <= RB; j++) begin
        if (j == RB && r == 3) break;
        want = (j == RB) ? 2'b00 : ((r % 2 == 0) ? 2'b01 : 2'b10);
        got  = (first >= 0 && first + r*(RB+1) + j < sel_trace.size()) ? sel_trace[first + r*(RB+1) + j] : 2'b11;
        if (got !== want) bad_pat++;
      end
    end
    n_cmp++; if (bad_pat != 0) begin n_bad++; $display("FAIL rr sel_pattern: got %0d wrong cycles want 0", bad_pat); end
  endtask

  task automatic test_stall();
    int mdl_cnt;
    bit prev_stall;
    logic [W-1:0] prev_out, cur_out;
    reset_dut();
    rx_q.delete(); exp_q.delete();
    start_src(0, RB, 8'h00);
    push_record(1'b0, 8'h00);
    mdl_cnt = 0; prev_stall = 1'b0; prev_out = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      ready = (cyc % 2 == 0);
      @(negedge clk);
      cur_out = {bus.out_src, bus.out_last, bus.out_data};
      if (mdl_cnt == 2) begin
        n_cmp++; if (bus.omux_sel !== 2'b00) begin n_bad++; $display("FAIL stall sel_at_full: got %b want 00", bus.omux_sel); end
      end
      n_cmp++; if (bus.out_valid !== (mdl_cnt != 0)) begin n_bad++; $display("FAIL stall valid: got %b want %b", bus.out_valid, (mdl_cnt != 0)); end
      if (prev_stall) begin
        n_cmp++; if (cur_out !== prev_out) begin n_bad++; $display("FAIL stall hold: got %h want %h", cur_out, prev_out); end
      end
      prev_stall = bus.out_valid && !ready;
      prev_out   = cur_out;
      mdl_cnt    = mdl_cnt + (|bus.omux_sel ? 1 : 0) - ((bus.out_valid && ready) ? 1 : 0);
      @(posedge clk); #1;
      if (rx_q.size() >= RB && mdl_cnt == 0) break;
    end
    ready = 1'b1;
    compare_rx("stall");
  endtask

  task automatic test_req_drop();
    bit ok;
    reset_dut();
    rx_q.delete(); exp_q.delete();
    ready = 1'b1;
    start_src(0, RB, 8'h00);
    start_src(1, RB, 8'h80);
    push_record(1'b0, 8'h00);
    push_record(1'b1, 8'h80);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (taken[0] - origin[0] >= 6) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop reach_byte6 timeout: got %0d want 6", taken[0] - origin[0]); end
    hold[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.omux_sel !== 2'b00) begin n_bad++; $display("FAIL drop sel_low[%0d]: got %b want 00", c, bus.omux_sel); end
      n_cmp++; if (dut_state !== ST_XFER) begin n_bad++; $display("FAIL drop state[%0d]: got %0d want XFER", c, dut_state); end
      @(posedge clk); #1;
    end
    hold[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.omux_sel !== 2'b01) begin n_bad++; $display("FAIL drop resume_sel: got %b want 01", bus.omux_sel); end
    @(posedge clk); #1;
    wait_rx(2*RB, 150, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop timeout: got %0d bytes want %0d", rx_q.size(), 2*RB); end
    idle_cycles(3);
    compare_rx("drop");
    @(negedge clk);
    n_cmp++; if (records_sent !== 32'd2) begin n_bad++; $display("FAIL drop records: got %0d want 2", records_sent); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    rx_q.delete(); exp_q.delete();
    ready = 1'b1;
    start_src(0, RB, 8'h00);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (taken[0] - origin[0] >= 8) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid reach_byte8 timeout: got %0d want 8", taken[0] - origin[0]); end
    reset = 1'b1;
    start_src(0, 0, 8'h00);
    start_src(1, RB, 8'h80);
    @(posedge clk); #1;
    reset = 1'b0;
    rx_q.delete();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (records_sent !== 32'd0) begin n_bad++; $display("FAIL rstmid records: got %0d want 0", records_sent); end
    n_cmp++; if (bus.omux_sel !== 2'b00) begin n_bad++; $display("FAIL rstmid sel: got %b want 00", bus.omux_sel); end
    n_cmp++; if (dut_state !== ST_IDLE) begin n_bad++; $display("FAIL rstmid state: got %0d want IDLE", dut_state); end
    push_record(1'b1, 8'h80);
    @(posedge clk); #1;
    wait_rx(RB, 80, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid timeout: got %0d bytes want %0d", rx_q.size(), RB); end
    idle_cycles(3);
    compare_rx("rstmid");
    @(negedge clk);
    n_cmp++; if (records_sent !== 32'd1) begin n_bad++; $display("FAIL rstmid records_after: got %0d want 1", records_sent); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bit ok;
    rx_q.delete(); exp_q.delete();
    ready = 1'b1;
    force dut.records_q = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++; if (records_sent !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap preload: got %h want ffffffff", records_sent); end
    @(posedge clk); #1;
    release dut.records_q;
    start_src(0, RB, 8'h40);
    push_record(1'b0, 8'h40);
    wait_rx(RB, 80, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap timeout: got %0d bytes want %0d", rx_q.size(), RB); end
    idle_cycles(3);
    compare_rx("wrap");
    @(negedge clk);
    n_cmp++; if (records_sent !== 32'd0) begin n_bad++; $display("FAIL wrap records: got %h want 00000000", records_sent); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < NSRC; k++) begin
      hold[k] = 1'b0;
      base[k] = 8'h00;
    end
    test_reset();
    test_single_record();
    test_round_robin();
    test_stall();
    test_req_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
